// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state encoding and grant-source constants
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of D grants taken while fetch waits (clk, rst async low, inc, clr, limit -> at_limit)
module arb_starve_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic       at_limit
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt < limit) cnt <= cnt + 4'd1;
  assign at_limit = cnt >= limit;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (if_*) and load/store (ls_*), driving mem_* with D priority and fetch starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_valid,
  output logic                stall_if,
  output logic                stall_ls,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_t state, nxt;
  logic at_limit, grant_d, grant_i, src;
  assign grant_d = state == IDLE && ls_req && (!if_req || !at_limit);
  assign grant_i = state == IDLE && !grant_d && if_req;
  assign src = grant_d ? GNT_D : GNT_I;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (grant_d ? GRANT_D : grant_i ? GRANT_I : IDLE) : mem_ready ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_d || grant_i) begin
      mem_we    <= src == GNT_D && ls_we;
      mem_addr  <= src == GNT_D ? ls_addr : if_addr;
      mem_wdata <= src == GNT_D ? ls_wdata : '0;
      mem_wstrb <= src == GNT_D ? ls_wstrb : '0;
    end
  arb_starve_cnt u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d && if_req),
    .clr      (grant_i || !if_req),
    .limit    (4'(STARVE_MAX)),
    .at_limit (at_limit)
  );
  assign mem_req  = state != IDLE;
  assign if_valid = state == GRANT_I && mem_ready;
  assign ls_valid = state == GRANT_D && mem_ready;
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign ls_rdata = ls_valid && !mem_we ? mem_rdata : '0;
  // rst gating keeps stalls low while the pipeline is held in reset
  assign stall_if = rst && if_req && !if_valid;
  assign stall_ls = rst && ls_req && !ls_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0, rst = 0;
  logic if_req = 0, ls_req = 0, ls_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [3:0] ls_wstrb = 0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic if_valid, ls_valid, stall_if, stall_ls, mem_req, mem_we;
  int tests = 0, fails = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_rdata(ls_rdata), .ls_valid(ls_valid), .stall_if(stall_if), .stall_ls(stall_ls),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 0; if_req = 1; ls_req = 1; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    #2;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_valid, ls_valid, if_rdata, ls_rdata, stall_if, stall_ls} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h wstrb=%h iv=%b lv=%b ir=%h lr=%h si=%b sl=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_valid, ls_valid, if_rdata, ls_rdata, stall_if, stall_ls);
    end
    tick;
    if_req = 0; ls_req = 0; mem_ready = 0; mem_rdata = 0;
    #2 rst = 1;
    tick;
  endtask
  task automatic test_single_fetch;
    if_req = 1; if_addr = 32'h100;
    #1;
    tests++;
    if ({mem_req, stall_if, if_valid} !== 3'b010) begin fails++; $display("FAIL fetch_c0: req/stall/valid=%b want 010", {mem_req, stall_if, if_valid}); end
    tick;
    tests++;
    if ({mem_req, mem_we, stall_if, if_valid} !== 4'b1010 || mem_addr !== 32'h100 || mem_wstrb !== 4'h0) begin
      fails++; $display("FAIL fetch_c1: req/we/stall/valid=%b addr=%h wstrb=%h want 1010 100 0", {mem_req, mem_we, stall_if, if_valid}, mem_addr, mem_wstrb);
    end
    tick;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    tests++;
    if ({if_valid, stall_if, ls_valid} !== 3'b100 || if_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL fetch_c2: valid/stall/lsv=%b rdata=%h want 100 deadbeef", {if_valid, stall_if, ls_valid}, if_rdata);
    end
    tick;
    if_req = 0; mem_ready = 0;
    #1;
    tests++;
    if ({mem_req, if_valid} !== 2'b00) begin fails++; $display("FAIL fetch_c3: req/valid=%b want 00", {mem_req, if_valid}); end
    tick;
  endtask
  task automatic test_store_wait;
    int pulses;
    pulses = 0;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'h12345678; ls_wstrb = 4'b0011;
    tick;
    ls_addr = 32'hFFFF_0000; ls_wdata = 32'h0; ls_wstrb = 4'hF; ls_we = 0;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c == 4); mem_rdata = 32'hCAFE_F00D;
      #1;
      tests++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h2004 || mem_wdata !== 32'h12345678 || mem_wstrb !== 4'b0011 ||
          ls_valid !== (c == 4) || stall_ls !== (c != 4) || ls_rdata !== 32'h0) begin
        fails++;
        $display("FAIL store_c%0d: req=%b we=%b addr=%h wdata=%h wstrb=%b lv=%b sl=%b lr=%h want 1 1 2004 12345678 0011 %b %b 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ls_valid, stall_ls, ls_rdata, c == 4, c != 4);
      end
      if (ls_valid) pulses++;
      tick;
    end
    ls_req = 0; mem_ready = 0;
    #1;
    if (ls_valid) pulses++;
    tests++;
    if (pulses != 1 || mem_req !== 1'b0) begin fails++; $display("FAIL store_once: pulses=%0d req=%b want 1 0", pulses, mem_req); end
    tick;
  endtask
  task automatic test_simultaneous;
    if_req = 1; if_addr = 32'h300; ls_req = 1; ls_we = 0; ls_addr = 32'h400;
    tick;
    mem_ready = 1; mem_rdata = 32'hA5A5_A5A5;
    #1;
    tests++;
    if ({mem_req, mem_we, ls_valid, if_valid, stall_if} !== 5'b10101 || mem_addr !== 32'h400 || ls_rdata !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL simul_d: req/we/lv/iv/si=%b addr=%h lr=%h want 10101 400 a5a5a5a5", {mem_req, mem_we, ls_valid, if_valid, stall_if}, mem_addr, ls_rdata);
    end
    tick;
    ls_req = 0; mem_ready = 0;
    #1;
    tests++;
    if ({mem_req, if_valid, ls_valid} !== 3'b000) begin fails++; $display("FAIL simul_gap: req/iv/lv=%b want 000", {mem_req, if_valid, ls_valid}); end
    tick;
    mem_ready = 1; mem_rdata = 32'h5A5A_5A5A;
    #1;
    tests++;
    if ({mem_req, mem_we, if_valid, ls_valid} !== 4'b1010 || mem_addr !== 32'h300 || if_rdata !== 32'h5A5A_5A5A) begin
      fails++; $display("FAIL simul_i: req/we/iv/lv=%b addr=%h ir=%h want 1010 300 5a5a5a5a", {mem_req, mem_we, if_valid, ls_valid}, mem_addr, if_rdata);
    end
    tick;
    if_req = 0; mem_ready = 0;
    tick;
  endtask
  task automatic test_starvation;
    if_req = 1; if_addr = 32'h500; ls_req = 1; ls_we = 0; ls_addr = 32'h600; mem_ready = 1; mem_rdata = 32'h77;
    for (int k = 0; k < 10; k++) begin
      tick;
      tests++;
      if (k % 5 == 4) begin
        if (!mem_req || mem_addr !== 32'h500 || {if_valid, ls_valid} !== 2'b10) begin
          fails++; $display("FAIL starve_grant%0d: req=%b addr=%h iv/lv=%b want 1 500 10", k, mem_req, mem_addr, {if_valid, ls_valid});
        end
      end else if (!mem_req || mem_addr !== 32'h600 || {if_valid, ls_valid} !== 2'b01) begin
        fails++; $display("FAIL starve_grant%0d: req=%b addr=%h iv/lv=%b want 1 600 01", k, mem_req, mem_addr, {if_valid, ls_valid});
      end
      tick;
      tests++;
      if ({mem_req, if_valid, ls_valid} !== 3'b000) begin
        fails++; $display("FAIL starve_idle%0d: req/iv/lv=%b want 000", k, {mem_req, if_valid, ls_valid});
      end
    end
    if_req = 0; ls_req = 0; mem_ready = 0;
    tick;
  endtask
  task automatic test_reset_mid;
    ls_req = 1; ls_we = 0; ls_addr = 32'h700;
    tick;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin fails++; $display("FAIL midrst_grant: req=%b addr=%h want 1 700", mem_req, mem_addr); end
    #1 rst = 0;
    #1;
    tests++;
    if ({mem_req, ls_valid, mem_addr} !== '0) begin fails++; $display("FAIL midrst_async: req=%b lv=%b addr=%h want 0 0 0", mem_req, ls_valid, mem_addr); end
    ls_req = 0;
    tick;
    #2 rst = 1;
    tick;
    if_req = 1; if_addr = 32'h800;
    tick;
    mem_ready = 1; mem_rdata = 32'h8888;
    #1;
    tests++;
    if ({mem_req, if_valid, ls_valid} !== 3'b110 || mem_addr !== 32'h800 || if_rdata !== 32'h8888) begin
      fails++; $display("FAIL midrst_after: req/iv/lv=%b addr=%h ir=%h want 110 800 8888", {mem_req, if_valid, ls_valid}, mem_addr, if_rdata);
    end
    tick;
    if_req = 0; mem_ready = 0;
    tick;
  endtask
  task automatic test_stray_ready;
    mem_ready = 1; mem_rdata = 32'h123;
    #1;
    tests++;
    if ({mem_req, if_valid, ls_valid} !== 3'b000 || if_rdata !== 0 || ls_rdata !== 0) begin
      fails++; $display("FAIL stray_now: req/iv/lv=%b ir=%h lr=%h want 000 0 0", {mem_req, if_valid, ls_valid}, if_rdata, ls_rdata);
    end
    tick;
    tick;
    tests++;
    if ({mem_req, if_valid, ls_valid} !== 3'b000) begin fails++; $display("FAIL stray_idle: req/iv/lv=%b want 000", {mem_req, if_valid, ls_valid}); end
    mem_ready = 0;
    tick;
  endtask
  initial begin
    test_reset;
    test_single_fetch;
    test_store_wait;
    test_simultaneous;
    test_starvation;
    test_reset_mid;
    test_stray_ready;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
